rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter AW, default 12, word-address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter STARVE_MAX, default 3, consecutive fetch-denied cycles before fetch is forced to win (legal range 1..15).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 if_req  input  1  instruction-fetch read request.
REQ-007 if_addr  input  AW  fetch word address.
REQ-008 if_flush  input  1  discard any in-flight fetch response (branch/jump taken).
REQ-009 if_gnt  output  1  fetch request accepted this cycle.
REQ-010 if_rvalid  output  1  fetch read data valid.
REQ-011 if_rdata  output  DW  fetch read data.
REQ-012 ls_req  input  1  load read request.
REQ-013 ls_addr  input  AW  load word address.
REQ-014 ls_gnt  output  1  load request accepted this cycle.
REQ-015 ls_rvalid  output  1  load read data valid.
REQ-016 ls_rdata  output  DW  load read data.
REQ-017 mem_en  output  1  single-port ROM read enable.
REQ-018 mem_addr  output  AW  ROM read address.
REQ-019 mem_rdata  input  DW  ROM data, valid the cycle after mem_en.

Function
REQ-020 Requester SHALL hold req high and addr stable until gnt; gnt is combinational in the same cycle as the accepted req.
REQ-021 At most one of if_gnt/ls_gnt SHALL be high per cycle; mem_en SHALL equal if_gnt | ls_gnt.
REQ-022 mem_addr SHALL be the granted requester's address; when no grant, mem_addr SHALL be 0.
REQ-023 Default priority: ls_req wins over if_req.
REQ-024 starve_cnt (4 bits) SHALL increment, saturating at STARVE_MAX, each cycle if_req=1 and if_gnt=0; it SHALL clear when if_gnt=1 or if_req=0.
REQ-025 When starve_cnt == STARVE_MAX and if_req=1, if_gnt SHALL be 1 and ls_gnt 0, regardless of ls_req.
REQ-026 Read latency SHALL be exactly 1 cycle: a grant in cycle N gives rvalid=1 to the same requester in cycle N+1, with rdata = mem_rdata.
REQ-027 A registered owner bit SHALL record the grant owner; a registered pend bit SHALL mark a response due next cycle.
REQ-028 Back-to-back grants (any owner mix) SHALL be accepted every cycle with no bubble.
REQ-029 if_rvalid SHALL be 0 in cycle N+1 if if_flush=1 in cycle N (grant cycle) or in cycle N+1 (response cycle); ls responses SHALL be unaffected by if_flush.
REQ-030 if_flush SHALL NOT block a new fetch grant in the same cycle; that new grant's response SHALL still be subject to REQ-029.
REQ-031 if_rdata/ls_rdata SHALL be 0 whenever their rvalid is 0.
REQ-032 No grant SHALL be issued in any cycle with rst=1.

Reset
REQ-033 While rst=1: if_gnt, ls_gnt, mem_en, if_rvalid, ls_rvalid = 0; mem_addr, if_rdata, ls_rdata = 0.
REQ-034 On the clock edge with rst=1: starve_cnt, owner, pend SHALL clear to 0.
REQ-035 Reset asserted the cycle after a grant SHALL suppress that grant's rvalid; no response SHALL appear after reset deasserts without a new grant.

Verification
REQ-036 if_req=1, addr=5, ls_req=0, ROM[5]=0x00A00093 -> if_gnt same cycle, next cycle if_rvalid=1, if_rdata=0x00A00093.
REQ-037 if_req and ls_req held high continuously, STARVE_MAX=3 -> grant pattern ls,ls,ls,if repeating; every grant's rvalid 1 cycle later to the correct owner.
REQ-038 Alternating ls(addr 2)/if(addr 3) grants in consecutive cycles -> ls_rvalid then if_rvalid on consecutive cycles, data ROM[2] then ROM[3], no bubble.
REQ-039 if granted cycle N, if_flush=1 in cycle N+1 -> if_rvalid=0 and if_rdata=0 in N+1; a simultaneous ls response in N+1 still delivered.
REQ-040 rst=1 one cycle after an ls grant -> ls_rvalid=0, starve_cnt=0; after rst=0 with no req, all outputs remain 0.

Source files
------------

// File: rtl/rom_arbiter_if.sv
// Request/response bundle between the fetch/load requesters, the ROM and the arbiter.
interface rom_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req;
    logic [AW-1:0] ls_addr;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush, ls_req, ls_addr, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_en, mem_addr
    );

    modport master (
        output if_req, if_addr, if_flush, ls_req, ls_addr, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_en, mem_addr
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-requester arbiter for a single-port ROM: loads win by default, fetch is
// forced through after STARVE_MAX denied cycles; fixed 1-cycle read latency.
module rom_arbiter #(
    parameter int AW         = 12,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic           clk,
    input  logic           rst,
    rom_arbiter_if.slave   bus
);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0]    starve_cnt;
    logic          owner;   // 1 = fetch owns the response in flight
    logic          pend;
    logic          force_if;
    logic          if_gnt;
    logic          ls_gnt;
    logic [AW-1:0] addr_mux;

    assign force_if = bus.if_req && (starve_cnt == SMAX);
    assign if_gnt   = !rst && bus.if_req && (force_if || !bus.ls_req);
    assign ls_gnt   = !rst && bus.ls_req && !if_gnt;

    always_comb begin
        addr_mux = '0;
        if (if_gnt)      addr_mux = bus.if_addr;
        else if (ls_gnt) addr_mux = bus.ls_addr;
    end

    assign bus.if_gnt   = if_gnt;
    assign bus.ls_gnt   = ls_gnt;
    assign bus.mem_en   = if_gnt | ls_gnt;
    assign bus.mem_addr = addr_mux;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
            owner      <= 1'b0;
            pend       <= 1'b0;
        end else begin
            if (bus.if_req && !if_gnt)
                starve_cnt <= (starve_cnt == SMAX) ? starve_cnt : starve_cnt + 4'd1;
            else
                starve_cnt <= 4'd0;
            owner <= if_gnt;
            // A fetch granted under flush is already dead; never mark it due.
            pend  <= ls_gnt | (if_gnt & !bus.if_flush);
        end
    end

    assign bus.if_rvalid = !rst && pend && owner && !bus.if_flush;
    assign bus.ls_rvalid = !rst && pend && !owner;
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : {DW{1'b0}};
    assign bus.ls_rdata  = bus.ls_rvalid ? bus.mem_rdata : {DW{1'b0}};
endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a behavioural ROM behind mem_en/mem_addr.
module tb_rom_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errs    = 0;

    always #5 clk = ~clk;

    rom_arbiter_if #(.AW(12), .DW(32)) bus ();

    rom_arbiter #(.AW(12), .DW(32), .STARVE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [31:0] rom(input logic [11:0] a);
        if (a == 12'd5) return 32'h00A00093;
        return 32'hC0DE0000 | {20'd0, a};
    endfunction

    always @(posedge clk) begin
        if (rst)             bus.mem_rdata <= 32'd0;
        else if (bus.mem_en) bus.mem_rdata <= rom(bus.mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #3;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_if_gnt"},    32'(bus.if_gnt), 32'd0);
        chk({tag, "_ls_gnt"},    32'(bus.ls_gnt), 32'd0);
        chk({tag, "_mem_en"},    32'(bus.mem_en), 32'd0);
        chk({tag, "_mem_addr"},  32'(bus.mem_addr), 32'd0);
        chk({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
        chk({tag, "_ls_rvalid"}, 32'(bus.ls_rvalid), 32'd0);
        chk({tag, "_if_rdata"},  bus.if_rdata, 32'd0);
        chk({tag, "_ls_rdata"},  bus.ls_rdata, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 12'd5; bus.if_flush = 1'b0;
        bus.ls_req = 1'b1; bus.ls_addr = 12'd9;
        tick; tick;
        settle;
        chk_idle("reset");

        // single fetch, ROM[5]
        tick;
        rst = 1'b0; bus.ls_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 12'd5;
        settle;
        chk("f1_if_gnt",   32'(bus.if_gnt), 32'd1);
        chk("f1_ls_gnt",   32'(bus.ls_gnt), 32'd0);
        chk("f1_mem_en",   32'(bus.mem_en), 32'd1);
        chk("f1_mem_addr", 32'(bus.mem_addr), 32'd5);
        tick;
        bus.if_req = 1'b0;
        settle;
        chk("f1_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("f1_if_rdata",  bus.if_rdata, 32'h00A00093);
        chk("f1_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
        chk("f1_mem_addr0", 32'(bus.mem_addr), 32'd0);

        // both held: ls,ls,ls,if repeating
        tick;
        bus.if_req = 1'b1; bus.if_addr = 12'd7;
        bus.ls_req = 1'b1; bus.ls_addr = 12'd9;
        for (int i = 0; i < 8; i++) begin
            settle;
            chk($sformatf("st%0d_if_gnt", i), 32'(bus.if_gnt), (i % 4 == 3) ? 32'd1 : 32'd0);
            chk($sformatf("st%0d_ls_gnt", i), 32'(bus.ls_gnt), (i % 4 == 3) ? 32'd0 : 32'd1);
            chk($sformatf("st%0d_mem_addr", i), 32'(bus.mem_addr), (i % 4 == 3) ? 32'd7 : 32'd9);
            if (i > 0) begin
                chk($sformatf("st%0d_if_rvalid", i), 32'(bus.if_rvalid), (i % 4 == 0) ? 32'd1 : 32'd0);
                chk($sformatf("st%0d_ls_rvalid", i), 32'(bus.ls_rvalid), (i % 4 == 0) ? 32'd0 : 32'd1);
                chk($sformatf("st%0d_rdata", i), bus.if_rdata | bus.ls_rdata,
                    (i % 4 == 0) ? 32'hC0DE0007 : 32'hC0DE0009);
            end
            tick;
        end
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        settle;
        chk("st_drain_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("st_drain_if_rdata",  bus.if_rdata, 32'hC0DE0007);
        chk("st_drain_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);

        // ls(2) then if(3) back to back
        tick;
        bus.ls_req = 1'b1; bus.ls_addr = 12'd2;
        bus.if_req = 1'b1; bus.if_addr = 12'd3;
        settle;
        chk("bb_ls_gnt", 32'(bus.ls_gnt), 32'd1);
        chk("bb_if_gnt0", 32'(bus.if_gnt), 32'd0);
        tick;
        bus.ls_req = 1'b0;
        settle;
        chk("bb_if_gnt",    32'(bus.if_gnt), 32'd1);
        chk("bb_ls_rvalid", 32'(bus.ls_rvalid), 32'd1);
        chk("bb_ls_rdata",  bus.ls_rdata, 32'hC0DE0002);
        chk("bb_if_rdata0", bus.if_rdata, 32'd0);
        tick;
        bus.if_req = 1'b0;
        settle;
        chk("bb_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("bb_if_rdata",  bus.if_rdata, 32'hC0DE0003);
        chk("bb_ls_rvalid0", 32'(bus.ls_rvalid), 32'd0);

        // flush in the response cycle, flush in the grant cycle
        tick;
        bus.if_req = 1'b1; bus.if_addr = 12'd4;
        settle;
        chk("fl_if_gnt", 32'(bus.if_gnt), 32'd1);
        tick;
        bus.if_req = 1'b0; bus.if_flush = 1'b1;
        bus.ls_req = 1'b1; bus.ls_addr = 12'd6;
        settle;
        chk("fl_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("fl_if_rdata",  bus.if_rdata, 32'd0);
        chk("fl_ls_gnt",    32'(bus.ls_gnt), 32'd1);
        tick;
        bus.ls_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 12'd8;
        settle;
        chk("fl_ls_rvalid", 32'(bus.ls_rvalid), 32'd1);
        chk("fl_ls_rdata",  bus.ls_rdata, 32'hC0DE0006);
        chk("fl_new_if_gnt", 32'(bus.if_gnt), 32'd1);
        chk("fl_new_mem_addr", 32'(bus.mem_addr), 32'd8);
        tick;
        bus.if_flush = 1'b0; bus.if_req = 1'b0;
        settle;
        chk("fl_gcyc_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("fl_gcyc_if_rdata",  bus.if_rdata, 32'd0);

        // reset right after an ls grant
        tick;
        bus.ls_req = 1'b1; bus.ls_addr = 12'd1; bus.if_req = 1'b1; bus.if_addr = 12'd2;
        settle;
        chk("rs_ls_gnt", 32'(bus.ls_gnt), 32'd1);
        tick;
        rst = 1'b1; bus.ls_req = 1'b0; bus.if_req = 1'b0;
        settle;
        chk("rs_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
        chk("rs_ls_rdata",  bus.ls_rdata, 32'd0);
        tick;
        rst = 1'b0;
        settle;
        chk("rs_starve_cnt", 32'(dut.starve_cnt), 32'd0);
        chk_idle("post_rst0");
        tick;
        settle;
        chk_idle("post_rst1");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
